rgb565_grayscale_ise: RTL and testbench
=======================================

Name: rgb565_grayscale_ise

Overview:
Custom-instruction extension (ISE) for the CPU that converts one RGB565 pixel to an 8-bit luminance value. It attaches to the CPU custom-instruction bus (start/iseId/valueA/valueB in, done/result out). It responds only when the instruction ID on the bus matches its parameterised ID. Used by the camera/display path to turn colour pixels into grayscale with one instruction.

Parameters:
customInstructionId, 8'h00, ISE identifier this instance responds to.

Ports:
clock  input  1  system clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  CPU asserts to issue a custom instruction (one cycle per issue, or held high for back-to-back issues).
valueA  input  32  operand A; bits [15:0] = RGB565 pixel (R=[15:11], G=[10:5], B=[4:0]); bits [31:16] ignored.
valueB  input  32  operand B; unused, ignored.
iseId  input  8  instruction ID from CPU.
done  output  1  high for one cycle per accepted issue; result is valid in the same cycle.
result  output  32  {24'b0, gray[7:0]} when done, else 32'd0.

Behaviour:
- Select: sel = start AND (iseId == customInstructionId). Mismatched IDs are ignored entirely; done stays 0.
- Channel expansion to 8 bits, zero-padded LSBs: r8 = {R,3'b000}, g8 = {G,2'b00}, b8 = {B,3'b000}.
- Luminance: sum = r8*54 + g8*183 + b8*19 (coefficients sum to 256). Use a 16-bit unsigned sum; max 64220 does not overflow. gray = sum[15:8], i.e. truncate, no rounding.
- Latency 1 cycle. On the rising edge where sel=1, register done<=1 and result<={24'b0,gray}. On edges where sel=0, done<=0 and result<=0.
- Back-to-back: start held high with a new valueA every cycle gives one result per cycle, each one cycle later. No stall and no busy state.
- Reset: while reset=1 at a rising edge, done<=0 and result<=0, overriding sel. An issue presented during reset is dropped. The first issue accepted is the one at the first edge with reset=0.
- result is never X after reset; outside done cycles it is exactly 0.
- No other state; valueB and valueA[31:16] never affect outputs.

Test Plan:
- Reset: reset=1 for 2 cycles with start=1, iseId=0, valueA=16'hFFFF -> done=0, result=0 throughout reset. Release reset -> next edge gives done=1, result=250.
- Red sweep: start=1, iseId=0, valueA[15:11]=0..31 one per cycle -> result one cycle later = (R*8*54)>>8; R=0->0, R=1->1, R=31->52.
- Green sweep: valueA[10:5]=0..63 one per cycle -> result = (G*4*183)>>8; G=1->2, G=63->180. Blue sweep: valueA[4:0]=0..31 -> result = (B*8*19)>>8; B=31->18, B=13->7.
- White and black: valueA=16'hFFFF -> 250; valueA=16'h0000 -> 0. valueA=32'hABCD_FFFF with valueB=32'hDEAD_BEEF -> still 250.
- ID mismatch: iseId=8'h01 with customInstructionId=8'h00, start=1 -> done=0, result=0. Instance with customInstructionId=8'h05 and iseId=8'h05 -> responds normally.
- Start deassert: start=1 for one cycle, then start=0 -> done high for exactly one cycle, and result returns to 0 the cycle after.

Source files
------------

// File: rtl/rgb565_grayscale_ise.sv
// RGB565 -> 8-bit luminance custom instruction.
// One result per accepted issue, registered one cycle after the issue edge.
module rgb565_grayscale_ise #(
    parameter logic [7:0] customInstructionId = 8'h00
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] valueA,
    input  logic [31:0] valueB,
    input  logic [7:0]  iseId,
    output logic        done,
    output logic [31:0] result
);

    logic        sel;
    logic [4:0]  red;
    logic [5:0]  green;
    logic [4:0]  blue;
    logic [7:0]  r8;
    logic [7:0]  g8;
    logic [7:0]  b8;
    logic [15:0] r_term;
    logic [15:0] g_term;
    logic [15:0] b_term;
    logic [15:0] lum_sum;
    logic [7:0]  gray;

    logic        done_q;
    logic        done_d;
    logic [31:0] result_q;
    logic [31:0] result_d;

    // The upper operand half and operand B carry no meaning for this instruction.
    logic unused_operands;
    assign unused_operands = &{1'b0, valueA[31:16], valueB};

    assign sel = start && (iseId == customInstructionId);

    assign red   = valueA[15:11];
    assign green = valueA[10:5];
    assign blue  = valueA[4:0];

    assign r8 = {red, 3'b000};
    assign g8 = {green, 2'b00};
    assign b8 = {blue, 3'b000};

    // Weights sum to 256, so the high byte of the sum is the luminance; the
    // largest possible sum (64220) fits in 16 bits.
    assign r_term  = 16'(r8) * 16'd54;
    assign g_term  = 16'(g8) * 16'd183;
    assign b_term  = 16'(b8) * 16'd19;
    assign lum_sum = r_term + g_term + b_term;
    assign gray    = lum_sum[15:8];

    always_comb begin
        done_d   = 1'b0;
        result_d = 32'd0;
        if (sel) begin
            done_d   = 1'b1;
            result_d = {24'd0, gray};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            done_q   <= 1'b0;
            result_q <= 32'd0;
        end else begin
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_rgb565_grayscale_ise.sv
// Scoreboard bench for rgb565_grayscale_ise: two instances (ID 0 and ID 5)
// share one stimulus stream; every driven cycle pushes the expected outputs.
module tb_rgb565_grayscale_ise;

    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] valueA;
    logic [31:0] valueB;
    logic [7:0]  iseId;
    logic        done0;
    logic [31:0] result0;
    logic        done5;
    logic [31:0] result5;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        done0;
        logic [31:0] res0;
        logic        done5;
        logic [31:0] res5;
        string       tag;
    } exp_t;

    exp_t exp_q[$];

    rgb565_grayscale_ise #(.customInstructionId(8'h00)) dut0 (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .valueA (valueA),
        .valueB (valueB),
        .iseId  (iseId),
        .done   (done0),
        .result (result0)
    );

    rgb565_grayscale_ise #(.customInstructionId(8'h05)) dut5 (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .valueA (valueA),
        .valueB (valueB),
        .iseId  (iseId),
        .done   (done5),
        .result (result5)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, got, got, expv, expv);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    function automatic int gray_model(input logic [31:0] a);
        int r, g, b;
        r = int'(a[15:11]) * 8;
        g = int'(a[10:5]) * 4;
        b = int'(a[4:0]) * 8;
        return (r * 54 + g * 183 + b * 19) / 256;
    endfunction

    // Drive one cycle of stimulus and queue what both instances must show after the edge.
    task automatic drive(input string tag, input logic rst, input logic st, input logic [7:0] id,
                         input logic [31:0] a, input logic [31:0] b, input int exp_gray);
        exp_t e;
        @(negedge clock);
        reset  = rst;
        start  = st;
        iseId  = id;
        valueA = a;
        valueB = b;
        e.tag   = tag;
        e.done0 = !rst && st && (id == 8'h00);
        e.res0  = e.done0 ? 32'(exp_gray) : 32'd0;
        e.done5 = !rst && st && (id == 8'h05);
        e.res5  = e.done5 ? 32'(exp_gray) : 32'd0;
        exp_q.push_back(e);
    endtask

    always @(posedge clock) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check_val({e.tag, ".done0"}, {31'd0, done0}, {31'd0, e.done0});
            check_val({e.tag, ".res0"}, result0, e.res0);
            check_val({e.tag, ".done5"}, {31'd0, done5}, {31'd0, e.done5});
            check_val({e.tag, ".res5"}, result5, e.res5);
        end
    end

    initial begin
        logic [31:0] a;
        logic [7:0]  id;
        logic [7:0]  ids [3];
        reset  = 1'b1;
        start  = 1'b0;
        iseId  = 8'h00;
        valueA = 32'd0;
        valueB = 32'd0;
        ids[0] = 8'h00;
        ids[1] = 8'h01;
        ids[2] = 8'h05;

        // Issues during reset are dropped; the first edge after release is accepted.
        drive("rst0", 1'b1, 1'b1, 8'h00, 32'h0000_FFFF, 32'd0, 250);
        drive("rst1", 1'b1, 1'b1, 8'h00, 32'h0000_FFFF, 32'd0, 250);
        drive("rel_white", 1'b0, 1'b1, 8'h00, 32'h0000_FFFF, 32'd0, 250);

        for (int r = 0; r < 32; r++) begin
            a = 32'(r) << 11;
            drive($sformatf("red%0d", r), 1'b0, 1'b1, 8'h00, a, 32'd0, gray_model(a));
        end
        drive("red1", 1'b0, 1'b1, 8'h00, 32'h0000_0800, 32'd0, 1);
        drive("red31", 1'b0, 1'b1, 8'h00, 32'h0000_F800, 32'd0, 52);

        for (int g = 0; g < 64; g++) begin
            a = 32'(g) << 5;
            drive($sformatf("grn%0d", g), 1'b0, 1'b1, 8'h00, a, 32'd0, gray_model(a));
        end
        drive("grn1", 1'b0, 1'b1, 8'h00, 32'h0000_0020, 32'd0, 2);
        drive("grn63", 1'b0, 1'b1, 8'h00, 32'h0000_07E0, 32'd0, 180);

        for (int b = 0; b < 32; b++) begin
            a = 32'(b);
            drive($sformatf("blu%0d", b), 1'b0, 1'b1, 8'h00, a, 32'd0, gray_model(a));
        end
        drive("blu31", 1'b0, 1'b1, 8'h00, 32'h0000_001F, 32'd0, 18);
        drive("blu13", 1'b0, 1'b1, 8'h00, 32'h0000_000D, 32'd0, 7);

        drive("white", 1'b0, 1'b1, 8'h00, 32'h0000_FFFF, 32'd0, 250);
        drive("black", 1'b0, 1'b1, 8'h00, 32'h0000_0000, 32'd0, 0);
        drive("upper_ign", 1'b0, 1'b1, 8'h00, 32'hABCD_FFFF, 32'hDEAD_BEEF, 250);

        drive("id_mis", 1'b0, 1'b1, 8'h01, 32'h0000_FFFF, 32'd0, 250);
        drive("id5", 1'b0, 1'b1, 8'h05, 32'h0000_FFFF, 32'd0, 250);
        drive("id5_mix", 1'b0, 1'b1, 8'h05, 32'h0000_1234, 32'd0, gray_model(32'h0000_1234));

        drive("pulse", 1'b0, 1'b1, 8'h00, 32'h0000_F800, 32'd0, 52);
        drive("idle0", 1'b0, 1'b0, 8'h00, 32'h0000_F800, 32'd0, 52);
        drive("idle1", 1'b0, 1'b0, 8'h00, 32'h0000_FFFF, 32'd0, 250);

        for (int i = 0; i < 40; i++) begin
            a  = $urandom;
            id = ids[$urandom_range(0, 2)];
            drive($sformatf("rnd%0d", i), 1'b0, 1'($urandom_range(0, 1)), id, a, $urandom,
                  gray_model(a));
        end

        drive("mid_rst", 1'b1, 1'b1, 8'h00, 32'h0000_FFFF, 32'd0, 250);
        drive("post_rst", 1'b0, 1'b1, 8'h00, 32'h0000_07E0, 32'd0, 180);
        drive("tail", 1'b0, 1'b0, 8'h00, 32'h0000_0000, 32'd0, 0);

        // Let the monitor drain the last expectation, bounded by a few cycles.
        for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(posedge clock);
        #2;
        check_val("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
